// File: rtl/janus_wbuf.sv
// ---------------------------------------------------------------------------
// janus_wbuf : posted-write buffer between the janus core bus and ram.
//
// Core writes are acknowledged as soon as they are queued and are drained to
// ram in order. Reads that hit a queued address are answered from the queue
// (newest matching entry wins). Reads that miss wait until the queue is empty
// and the memory FSM is idle, then go to ram, so ordering stays strict.
//
// Ports
//   clk_janus   in   1   clock, rising edge
//   rst_janus   in   1   synchronous active-high reset
//   cpu_cb      in   3   core request: 001 read, 010 write, 011 error probe
//   cpu_ab      in   AW  core address
//   cpu_dob     in   DW  core write data
//   cpu_cb_in   out  3   [0] ack pulse, [1] queue full, [2] error (with ack)
//   cpu_dib     out  DW  read data, valid in the ack cycle
//   mem_cb_out  out  3   ram command: 001 read, 010 write, 000 idle
//   mem_ab      out  AW  ram address
//   mem_dob     out  DW  ram write data
//   mem_cb_in   in   3   [0] ram ack, other bits ignored
//   mem_dib     in   DW  ram read data, valid with ram ack
//   wb_empty    out  1   queue empty and no ram access in flight
//   dbg_state   out  2   memory FSM state (IDLE=0, WR=1, RD=2)
//
// Handshake: the core holds a request level-stable until it sees the ack
// pulse; the buffer never samples a request in a cycle where its ack output
// is high, so one request is accepted exactly once. On the ram side the
// command, address and data stay stable from the first cycle of an access
// until the cycle in which mem_cb_in[0] is high; that cycle ends the access.
// ---------------------------------------------------------------------------
module janus_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk_janus,
  input  logic          rst_janus,
  input  logic [2:0]    cpu_cb,
  input  logic [AW-1:0] cpu_ab,
  input  logic [DW-1:0] cpu_dob,
  output logic [2:0]    cpu_cb_in,
  output logic [DW-1:0] cpu_dib,
  output logic [2:0]    mem_cb_out,
  output logic [AW-1:0] mem_ab,
  output logic [DW-1:0] mem_dob,
  input  logic [2:0]    mem_cb_in,
  input  logic [DW-1:0] mem_dib,
  output logic          wb_empty,
  output logic [1:0]    dbg_state
);

  localparam int AI = $clog2(DEPTH);
  localparam int PW = AI + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;

  logic [AW-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic          r_cpu_ack, r_cpu_err, r_full;
  logic [DW-1:0] r_cpu_dib;

  logic [PW-1:0] w_count, w_count_nxt;
  logic          w_wr_req, w_rd_req, w_err_req;
  logic          w_push, w_pop, w_hit, w_rd_hit, w_rd_miss, w_rd_done, w_mem_ack;
  logic [DW-1:0] w_hit_data;
  logic [AI-1:0] w_fidx;
  logic [AI-1:0] w_head;
  logic [2:0]    w_mem_cb;
  logic [AW-1:0] w_mem_ab;
  logic [DW-1:0] w_mem_dob;
  logic          w_unused_bits;

  assign w_unused_bits = &{1'b0, mem_cb_in[2:1]};

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_head  = r_rd_ptr[AI-1:0];

  // Requests are ignored while our own ack is high (the core drops it then).
  assign w_wr_req  = !r_cpu_ack && (cpu_cb == 3'b010);
  assign w_rd_req  = !r_cpu_ack && (cpu_cb == 3'b001);
  assign w_err_req = !r_cpu_ack && (cpu_cb == 3'b011);

  // Full is judged on the registered count, so a pop in the same cycle does
  // not make room for this cycle's push.
  assign w_push    = w_wr_req && (w_count < PW'(DEPTH));
  assign w_mem_ack = mem_cb_in[0];
  assign w_pop     = (r_state == ST_WR) && w_mem_ack;
  assign w_rd_done = (r_state == ST_RD) && w_mem_ack;
  assign w_rd_hit  = w_rd_req && w_hit;
  assign w_rd_miss = w_rd_req && !w_hit;

  assign w_count_nxt = w_count + PW'(w_push) - PW'(w_pop);

  // Forwarding: scan oldest to newest so the newest match wins. The head
  // entry still counts even if it is being popped this cycle.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_fidx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fidx = w_head + AI'(i);
      if ((PW'(i) < w_count) && (r_addr[w_fidx] == cpu_ab)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_fidx];
      end
    end
  end

  // Memory FSM: next state and ram-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_mem_cb    = 3'b000;
    w_mem_ab    = '0;
    w_mem_dob   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_miss && (w_count == '0)) w_state_nxt = ST_RD;
        else if (w_count != '0)           w_state_nxt = ST_WR;
      end
      ST_WR: begin
        w_mem_cb  = 3'b010;
        w_mem_ab  = r_addr[w_head];
        w_mem_dob = r_data[w_head];
        if (w_mem_ack) w_state_nxt = ST_IDLE;
      end
      ST_RD: begin
        w_mem_cb = 3'b001;
        w_mem_ab = cpu_ab;
        if (w_mem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_janus) begin
    if (rst_janus) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Queue storage needs no reset: only entries between the pointers are used.
  always_ff @(posedge clk_janus) begin
    if (w_push) begin
      r_addr[r_wr_ptr[AI-1:0]] <= cpu_ab;
      r_data[r_wr_ptr[AI-1:0]] <= cpu_dob;
    end
  end

  always_ff @(posedge clk_janus) begin
    if (rst_janus) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cpu_ack <= 1'b0;
      r_cpu_err <= 1'b0;
      r_full    <= 1'b0;
      r_cpu_dib <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_full    <= (w_count_nxt == PW'(DEPTH));
      r_cpu_ack <= w_push | w_err_req | w_rd_hit | w_rd_done;
      r_cpu_err <= w_err_req;
      if (w_rd_hit)       r_cpu_dib <= w_hit_data;
      else if (w_rd_done) r_cpu_dib <= mem_dib;
    end
  end

  assign cpu_cb_in  = {r_cpu_err, r_full, r_cpu_ack};
  assign cpu_dib    = r_cpu_dib;
  assign mem_cb_out = w_mem_cb;
  assign mem_ab     = w_mem_ab;
  assign mem_dob    = w_mem_dob;
  assign wb_empty   = (w_count == '0) && (r_state == ST_IDLE);
  assign dbg_state  = r_state;

endmodule
